// File: rtl/dcache_sweep_ctrl_if.sv
// Core/RAM signal bundle for the data-cache tag/valid sweep controller.
// The slave modport is the controller's view; master is the core/RAM side.
interface dcache_sweep_ctrl_if #(
  parameter int NumWords = 256,
  parameter int SetAssoc = 8
);
  localparam int AddrW = $clog2(NumWords);

  // Request side
  logic                flush_i;
  logic                flush_ack_o;
  logic                init_done_o;
  logic                req_i;
  logic                we_i;
  logic [AddrW-1:0]    addr_i;
  logic [SetAssoc-1:0] wmask_i;
  logic                gnt_o;

  // RAM side
  logic                ram_en_o;
  logic                ram_we_o;
  logic [AddrW-1:0]    ram_addr_o;
  logic [SetAssoc-1:0] ram_wmask_o;
  logic                ram_clr_o;

  modport slave (
    input  flush_i, req_i, we_i, addr_i, wmask_i,
    output flush_ack_o, init_done_o, gnt_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wmask_o, ram_clr_o
  );

  modport master (
    output flush_i, req_i, we_i, addr_i, wmask_i,
    input  flush_ack_o, init_done_o, gnt_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wmask_o, ram_clr_o
  );
endinterface

// File: rtl/dcache_sweep_ctrl.sv
// Tag/valid RAM sweep controller: clears every set after reset (INIT) and on a
// flush request (FLUSH), otherwise passes core accesses straight to the RAM.
module dcache_sweep_ctrl #(
  parameter int NumWords = 256,
  parameter int SetAssoc = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dcache_sweep_ctrl_if.slave bus
);
  localparam int AddrW = $clog2(NumWords);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NumWords - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e           state_q;
  logic [AddrW-1:0] cnt_q;
  logic             pending_q;
  logic             flush_ack_q;
  logic             init_done_q;

  logic sweep;
  logic last;

  assign sweep = (state_q != IDLE);
  assign last  = (cnt_q == LastIdx);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      flush_ack_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      flush_ack_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (bus.flush_i) pending_q <= 1'b1;
          if (last) begin
            // The init sweep already cleared everything a flush would.
            cnt_q       <= '0;
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            flush_ack_q <= pending_q | bus.flush_i;
            pending_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AddrW'(1);
          end
        end
        IDLE: begin
          // A level still high during the ack cycle belongs to the sweep just acked.
          if (bus.flush_i && !flush_ack_q) state_q <= FLUSH;
        end
        FLUSH: begin
          if (last) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            flush_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AddrW'(1);
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    bus.gnt_o       = 1'b0;
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wmask_o = '0;
    bus.ram_clr_o   = 1'b0;
    if (sweep) begin
      bus.ram_en_o    = 1'b1;
      bus.ram_we_o    = 1'b1;
      bus.ram_addr_o  = cnt_q;
      bus.ram_wmask_o = '1;
      bus.ram_clr_o   = 1'b1;
    end else begin
      bus.gnt_o       = bus.req_i;
      bus.ram_en_o    = bus.req_i;
      bus.ram_we_o    = bus.req_i & bus.we_i;
      bus.ram_addr_o  = bus.addr_i;
      bus.ram_wmask_o = bus.wmask_i;
    end
  end

  assign bus.flush_ack_o = flush_ack_q;
  assign bus.init_done_o = init_done_q;

  a_ack_single : assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_ack_q |=> !flush_ack_q);
  a_no_gnt_in_sweep : assert property (@(posedge clk_i) disable iff (!rst_ni)
    sweep |-> !bus.gnt_o);
  a_done_sticky : assert property (@(posedge clk_i) disable iff (!rst_ni)
    init_done_q |=> init_done_q);

endmodule

// File: tb/tb_dcache_sweep_ctrl.sv
// Bench for dcache_sweep_ctrl (NumWords=4, SetAssoc=2): directed vectors with
// literal checks plus a cycle-timeline model compared on every falling edge.
module tb_dcache_sweep_ctrl;
  localparam int N  = 4;
  localparam int SA = 2;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  dcache_sweep_ctrl_if #(.NumWords(N), .SetAssoc(SA)) bus ();

  dcache_sweep_ctrl #(.NumWords(N), .SetAssoc(SA)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: c counts cycles since reset release; a sweep occupies
  // cycles sweep_start .. sweep_start+N-1 and the ack lands on cycle ack_at.
  int c;
  int sweep_start;
  int ack_at;
  bit kind_init;
  bit init_flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c           = 0;
      sweep_start = 0;
      ack_at      = -1;
      kind_init   = 1'b1;
      init_flush  = 1'b0;
    end else begin
      int pos;
      pos = c - sweep_start;
      if (pos < N) begin
        if (kind_init && bus.flush_i) init_flush = 1'b1;
        if (pos == N - 1 && (!kind_init || init_flush)) ack_at = c + 1;
      end else if (bus.flush_i && c != ack_at) begin
        sweep_start = c + 1;
        kind_init   = 1'b0;
      end
      c = c + 1;
    end
  end

  always @(negedge clk) begin
    bit in_sweep;
    logic [1:0]    e_addr;
    logic [SA-1:0] e_mask;
    in_sweep = (c - sweep_start) < N;
    e_addr   = in_sweep ? 2'(c - sweep_start) : bus.addr_i;
    e_mask   = in_sweep ? {SA{1'b1}} : bus.wmask_i;
    check("m_gnt",       32'(bus.gnt_o),       32'(rst_n && !in_sweep && bus.req_i));
    check("m_ram_en",    32'(bus.ram_en_o),    32'(in_sweep ? 1'b1 : bus.req_i));
    check("m_ram_we",    32'(bus.ram_we_o),    32'(in_sweep ? 1'b1 : (bus.req_i & bus.we_i)));
    check("m_ram_addr",  32'(bus.ram_addr_o),  32'(e_addr));
    check("m_ram_wmask", 32'(bus.ram_wmask_o), 32'(e_mask));
    check("m_ram_clr",   32'(bus.ram_clr_o),   32'(in_sweep));
    check("m_flush_ack", 32'(bus.flush_ack_o), 32'(c == ack_at));
    check("m_init_done", 32'(bus.init_done_o), 32'(c >= N));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n        = 1'b0;
    bus.flush_i  = 1'b0;
    bus.req_i    = 1'b1;
    bus.we_i     = 1'b1;
    bus.addr_i   = 2'd3;
    bus.wmask_i  = 2'b01;

    // Held in reset: INIT view at counter 0, no grant.
    repeat (2) step();
    #2;
    check("rst_gnt",  32'(bus.gnt_o),       32'd0);
    check("rst_addr", 32'(bus.ram_addr_o),  32'd0);
    check("rst_clr",  32'(bus.ram_clr_o),   32'd1);
    check("rst_done", 32'(bus.init_done_o), 32'd0);

    // Init sweep with a stalled core request.
    step();
    rst_n = 1'b1;
    #2;
    check("init_addr0", 32'(bus.ram_addr_o),  32'd0);
    check("init_mask0", 32'(bus.ram_wmask_o), 32'd3);
    check("init_gnt0",  32'(bus.gnt_o),       32'd0);
    for (int k = 1; k < N; k++) begin
      step();
      #2;
      check("init_addr", 32'(bus.ram_addr_o), 32'(k));
      check("init_gnt",  32'(bus.gnt_o),      32'd0);
    end
    step();
    #2;
    check("idle_done",  32'(bus.init_done_o), 32'd1);
    check("idle_gnt",   32'(bus.gnt_o),       32'd1);
    check("idle_addr",  32'(bus.ram_addr_o),  32'd3);
    check("idle_clr",   32'(bus.ram_clr_o),   32'd0);
    check("idle_noack", 32'(bus.flush_ack_o), 32'd0);

    // One-cycle flush pulse together with a core read: core wins this cycle.
    step();
    bus.flush_i = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = 2'd2;
    #2;
    check("fl_gnt",   32'(bus.gnt_o),      32'd1);
    check("fl_addr",  32'(bus.ram_addr_o), 32'd2);
    check("fl_we",    32'(bus.ram_we_o),   32'd0);
    step();
    bus.flush_i = 1'b0;
    #2;
    check("fl_sw_addr0", 32'(bus.ram_addr_o), 32'd0);
    check("fl_sw_gnt0",  32'(bus.gnt_o),      32'd0);
    for (int k = 1; k < N; k++) begin
      step();
      #2;
      check("fl_sw_addr", 32'(bus.ram_addr_o), 32'(k));
    end
    step();
    #2;
    check("fl_ack",     32'(bus.flush_ack_o), 32'd1);
    check("fl_ack_gnt", 32'(bus.gnt_o),       32'd1);
    step();
    #2;
    check("fl_ack_off", 32'(bus.flush_ack_o), 32'd0);

    // Flush pulse inside a FLUSH sweep is ignored.
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    step();
    #2;
    check("ign_ack",  32'(bus.flush_ack_o), 32'd1);
    step();
    #2;
    check("ign_ack_off", 32'(bus.flush_ack_o), 32'd0);
    check("ign_clr1",    32'(bus.ram_clr_o),   32'd0);
    step();
    #2;
    check("ign_clr2", 32'(bus.ram_clr_o), 32'd0);

    // Flush during INIT cycle 2 is absorbed by the init sweep.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    step();
    #2;
    check("ip_ack",  32'(bus.flush_ack_o), 32'd1);
    check("ip_done", 32'(bus.init_done_o), 32'd1);
    step();
    #2;
    check("ip_ack_off", 32'(bus.flush_ack_o), 32'd0);
    check("ip_no_sweep", 32'(bus.ram_clr_o),  32'd0);

    // Flush held high: sweep(4), ack, idle, repeat with period 6.
    step();
    bus.flush_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 12) bus.flush_i = 1'b0;
      #2;
      check("hold_ack", 32'(bus.flush_ack_o), 32'(i == 5 || i == 11));
      check("hold_clr", 32'(bus.ram_clr_o),
            32'((i >= 1 && i <= 4) || (i >= 7 && i <= 10)));
    end

    // Reset pulse in FLUSH at counter 2 aborts with no ack.
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    step();
    #2;
    check("ab_addr2", 32'(bus.ram_addr_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check("ab_ack",  32'(bus.flush_ack_o), 32'd0);
    check("ab_done", 32'(bus.init_done_o), 32'd0);
    check("ab_addr", 32'(bus.ram_addr_o),  32'd0);
    check("ab_gnt",  32'(bus.gnt_o),       32'd0);
    step();
    step();
    rst_n = 1'b1;
    #2;
    check("ab_re_addr", 32'(bus.ram_addr_o),  32'd0);
    check("ab_re_done", 32'(bus.init_done_o), 32'd0);
    repeat (N) step();
    #2;
    check("ab_fin_done", 32'(bus.init_done_o), 32'd1);
    check("ab_fin_ack",  32'(bus.flush_ack_o), 32'd0);

    // Random core traffic in IDLE: zero-latency pass-through.
    repeat (40) begin
      step();
      bus.req_i   = 1'($urandom_range(0, 1));
      bus.we_i    = 1'($urandom_range(0, 1));
      bus.addr_i  = 2'($urandom_range(0, N - 1));
      bus.wmask_i = 2'($urandom_range(0, 3));
      #2;
      check("rnd_en",   32'(bus.ram_en_o),    32'(bus.req_i));
      check("rnd_we",   32'(bus.ram_we_o),    32'(bus.req_i & bus.we_i));
      check("rnd_addr", 32'(bus.ram_addr_o),  32'(bus.addr_i));
      check("rnd_mask", 32'(bus.ram_wmask_o), 32'(bus.wmask_i));
      check("rnd_clr",  32'(bus.ram_clr_o),   32'd0);
      check("rnd_gnt",  32'(bus.gnt_o),       32'(bus.req_i));
    end

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
